// File: rtl/spad_frame_duration_scheduler.sv
// rtl/spad_frame_duration_scheduler.sv - arbitrates host/AE frame-duration requests and commits them at controller frame boundaries
// Adoption by the controller is confirmed before the request is reported as applied.
module spad_frame_duration_scheduler #(
    parameter int DUR_W           = 20,
    parameter int MIN_DUR         = 16,
    parameter int MAX_DUR         = 1000000,
    parameter int RESET_DUR       = 1000,
    parameter int CONFIRM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             host_req_valid,
    input  logic [DUR_W-1:0] host_req_dur,
    output logic             host_req_ready,
    input  logic             ae_req_valid,
    input  logic [DUR_W-1:0] ae_req_dur,
    output logic             ae_req_ready,
    output logic [DUR_W-1:0] FrameDurationRequestedClks,
    input  logic             FrameDurationChangeEnable,
    input  logic [DUR_W-1:0] FrameDurationCurrentClks,
    output logic             applied_valid,
    output logic [DUR_W-1:0] applied_dur,
    output logic             applied_src,
    output logic             clamp_flag,
    output logic             busy,
    output logic             error,
    input  logic             error_clr
);

    localparam int CNT_W = $clog2(CONFIRM_TIMEOUT + 1);
    localparam logic [DUR_W-1:0] MIN_D = DUR_W'(MIN_DUR);
    localparam logic [DUR_W-1:0] MAX_D = DUR_W'(MAX_DUR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_BOUNDARY, CONFIRM} state_t;

    state_t           state, stateNext;
    logic             lastGrantAe;
    logic             prevCe;
    logic [CNT_W-1:0] cnt;
    logic             curSrc;

    logic             isIdle, grantHost, grantAe, accept;
    logic [DUR_W-1:0] rawDur, clampedDur;
    logic             ceRise, curMatch, timeoutHit, errorSet;

    // Round-robin: on a tie the requester that did not win last time is granted.
    always_comb begin
        isIdle     = (state == IDLE);
        grantHost  = host_req_valid && (!ae_req_valid || lastGrantAe);
        grantAe    = ae_req_valid && !grantHost;
        accept     = isIdle && (host_req_valid || ae_req_valid);
        rawDur     = grantHost ? host_req_dur : ae_req_dur;
        clampedDur = rawDur;
        if (rawDur < MIN_D) begin
            clampedDur = MIN_D;
        end else if (rawDur > MAX_D) begin
            clampedDur = MAX_D;
        end
        ceRise     = FrameDurationChangeEnable && !prevCe;
        curMatch   = (FrameDurationCurrentClks == FrameDurationRequestedClks);
        timeoutHit = (cnt == CNT_LAST);
        errorSet   = (state == CONFIRM) && !curMatch && timeoutHit;
    end

    assign host_req_ready = isIdle && grantHost;
    assign ae_req_ready   = isIdle && grantAe;
    assign busy           = !isIdle;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept && (clampedDur != FrameDurationCurrentClks)) begin
                    stateNext = WAIT_BOUNDARY;
                end
            end
            WAIT_BOUNDARY: begin
                if (ceRise) begin
                    stateNext = CONFIRM;
                end
            end
            CONFIRM: begin
                if (curMatch || timeoutHit) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            prevCe <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= stateNext;
            prevCe <= FrameDurationChangeEnable;
            cnt    <= (state == CONFIRM) ? cnt + 1'b1 : '0;
        end
    end

    // A request already in effect at accept is reported at once, skipping the boundary wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            FrameDurationRequestedClks <= DUR_W'(RESET_DUR);
            clamp_flag    <= 1'b0;
            curSrc        <= 1'b0;
            lastGrantAe   <= 1'b1;
            applied_valid <= 1'b0;
            applied_dur   <= '0;
            applied_src   <= 1'b0;
            error         <= 1'b0;
        end else begin
            applied_valid <= 1'b0;
            if (accept) begin
                FrameDurationRequestedClks <= clampedDur;
                clamp_flag  <= (clampedDur != rawDur);
                curSrc      <= grantAe;
                lastGrantAe <= grantAe;
                if (clampedDur == FrameDurationCurrentClks) begin
                    applied_valid <= 1'b1;
                    applied_dur   <= clampedDur;
                    applied_src   <= grantAe;
                end
            end
            if ((state == CONFIRM) && curMatch) begin
                applied_valid <= 1'b1;
                applied_dur   <= FrameDurationRequestedClks;
                applied_src   <= curSrc;
            end
            if (errorSet) begin
                error <= 1'b1;
            end else if (error_clr) begin
                error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spad_frame_duration_scheduler.sv
// tb/tb_spad_frame_duration_scheduler.sv - randomized self-checking bench for spad_frame_duration_scheduler
// Expectations come from transaction-level rules: grant order, clamp arithmetic and cycle budgets.
module tb_spad_frame_duration_scheduler;

    localparam int DUR_W = 20;

    logic             clk = 1'b0;
    logic             reset;
    logic             host_req_valid;
    logic [DUR_W-1:0] host_req_dur;
    logic             host_req_ready;
    logic             ae_req_valid;
    logic [DUR_W-1:0] ae_req_dur;
    logic             ae_req_ready;
    logic [DUR_W-1:0] FrameDurationRequestedClks;
    logic             FrameDurationChangeEnable;
    logic [DUR_W-1:0] FrameDurationCurrentClks;
    logic             applied_valid;
    logic [DUR_W-1:0] applied_dur;
    logic             applied_src;
    logic             clamp_flag;
    logic             busy;
    logic             error;
    logic             error_clr;

    int nCompared   = 0;
    int nMismatched = 0;
    logic modelLastAe;

    spad_frame_duration_scheduler dut (
        .clk                        (clk),
        .reset                      (reset),
        .host_req_valid             (host_req_valid),
        .host_req_dur               (host_req_dur),
        .host_req_ready             (host_req_ready),
        .ae_req_valid               (ae_req_valid),
        .ae_req_dur                 (ae_req_dur),
        .ae_req_ready               (ae_req_ready),
        .FrameDurationRequestedClks (FrameDurationRequestedClks),
        .FrameDurationChangeEnable  (FrameDurationChangeEnable),
        .FrameDurationCurrentClks   (FrameDurationCurrentClks),
        .applied_valid              (applied_valid),
        .applied_dur                (applied_dur),
        .applied_src                (applied_src),
        .clamp_flag                 (clamp_flag),
        .busy                       (busy),
        .error                      (error),
        .error_clr                  (error_clr)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampDur(input int raw);
        if (raw < 16) return 16;
        if (raw > 1000000) return 1000000;
        return raw;
    endfunction

    function automatic int randDur();
        int edges[6];
        edges = '{15, 16, 17, 999999, 1000000, 1000001};
        case ($urandom_range(0, 4))
            0: return 0;
            1: return int'($urandom_range(1, 15));
            2: return int'($urandom_range(16, 1000000));
            3: return int'($urandom_range(1000001, 1048575));
            default: return edges[$urandom_range(0, 5)];
        endcase
    endfunction

    // mode 0: value already in effect; 1: boundary then match; 2: boundary then timeout
    task automatic runTxn(input int mode);
        logic hv, av, winAe, earlyCe, curEarly, loserHeld, clrSame;
        int hd, ad, raw, d, gap, k;
        hv = 1'($urandom_range(0, 1));
        av = hv ? 1'($urandom_range(0, 1)) : 1'b1;
        hd = randDur();
        ad = randDur();
        winAe = (hv && av) ? !modelLastAe : av;
        raw = winAe ? ad : hd;
        d = clampDur(raw);
        earlyCe = (mode != 0) && ($urandom_range(0, 1) == 1);
        curEarly = (mode == 1) && ($urandom_range(0, 1) == 1);

        host_req_valid = hv;
        host_req_dur = DUR_W'(hd);
        ae_req_valid = av;
        ae_req_dur = DUR_W'(ad);
        FrameDurationCurrentClks = (mode == 0) ? DUR_W'(d) : DUR_W'(d + 1);
        FrameDurationChangeEnable = earlyCe;
        #1;
        checkVal("host_ready", 32'(host_req_ready), 32'(!winAe));
        checkVal("ae_ready", 32'(ae_req_ready), 32'(winAe));
        tick();
        modelLastAe = winAe;
        loserHeld = hv && av && (mode != 0);
        if (winAe) ae_req_valid = 1'b0; else host_req_valid = 1'b0;
        if (!loserHeld) begin
            host_req_valid = 1'b0;
            ae_req_valid = 1'b0;
        end
        checkVal("requested", 32'(FrameDurationRequestedClks), d);
        checkVal("clamp_flag", 32'(clamp_flag), 32'(d != raw));
        checkVal("busy_accept", 32'(busy), 32'(mode != 0));

        if (mode == 0) begin
            checkVal("imm_valid", 32'(applied_valid), 1);
            checkVal("imm_dur", 32'(applied_dur), d);
            checkVal("imm_src", 32'(applied_src), 32'(winAe));
            tick();
            checkVal("imm_pulse_end", 32'(applied_valid), 0);
            checkVal("imm_dur_held", 32'(applied_dur), d);
            return;
        end

        checkVal("no_pulse_accept", 32'(applied_valid), 0);
        if (earlyCe) begin
            repeat ($urandom_range(1, 3)) tick();
            FrameDurationChangeEnable = 1'b0;
        end
        if (curEarly) FrameDurationCurrentClks = DUR_W'(d);
        gap = $urandom_range(1, 20);
        repeat (gap) begin
            checkVal("wait_ready", 32'({host_req_ready, ae_req_ready}), 0);
            checkVal("wait_busy", 32'(busy), 1);
            checkVal("wait_no_pulse", 32'(applied_valid), 0);
            tick();
        end
        FrameDurationChangeEnable = 1'b1;
        tick();
        FrameDurationChangeEnable = 1'b0;
        checkVal("confirm_busy", 32'(busy), 1);
        checkVal("confirm_no_pulse", 32'(applied_valid), 0);

        if (mode == 1) begin
            k = curEarly ? 0 : int'($urandom_range(0, 63));
            repeat (k) begin
                tick();
                checkVal("confirm_wait_pulse", 32'(applied_valid), 0);
                checkVal("confirm_wait_busy", 32'(busy), 1);
            end
            FrameDurationCurrentClks = DUR_W'(d);
            tick();
            checkVal("applied_valid", 32'(applied_valid), 1);
            checkVal("applied_dur", 32'(applied_dur), d);
            checkVal("applied_src", 32'(applied_src), 32'(winAe));
            checkVal("applied_busy", 32'(busy), 0);
            checkVal("applied_error", 32'(error), 0);
            if (loserHeld) begin
                checkVal("loser_ready", 32'(winAe ? host_req_ready : ae_req_ready), 1);
                host_req_valid = 1'b0;
                ae_req_valid = 1'b0;
            end
            tick();
            checkVal("applied_pulse_end", 32'(applied_valid), 0);
        end else begin
            repeat (63) begin
                tick();
                checkVal("timeout_pending_err", 32'(error), 0);
                checkVal("timeout_pending_busy", 32'(busy), 1);
            end
            clrSame = 1'($urandom_range(0, 1));
            error_clr = clrSame;
            tick();
            error_clr = 1'b0;
            checkVal("timeout_error", 32'(error), 1);
            checkVal("timeout_busy", 32'(busy), 0);
            checkVal("timeout_no_pulse", 32'(applied_valid), 0);
            checkVal("timeout_requested", 32'(FrameDurationRequestedClks), d);
            if (loserHeld) begin
                checkVal("loser_ready", 32'(winAe ? host_req_ready : ae_req_ready), 1);
                host_req_valid = 1'b0;
                ae_req_valid = 1'b0;
            end
            error_clr = 1'b1;
            tick();
            error_clr = 1'b0;
            checkVal("error_cleared", 32'(error), 0);
            checkVal("clr_no_pulse", 32'(applied_valid), 0);
        end
    endtask

    task automatic checkResetState();
        checkVal("rst_requested", 32'(FrameDurationRequestedClks), 1000);
        checkVal("rst_busy", 32'(busy), 0);
        checkVal("rst_error", 32'(error), 0);
        checkVal("rst_valid", 32'(applied_valid), 0);
        checkVal("rst_clamp", 32'(clamp_flag), 0);
        checkVal("rst_ready", 32'({host_req_ready, ae_req_ready}), 0);
    endtask

    initial begin
        reset = 1'b0;
        host_req_valid = 1'b0;
        host_req_dur = '0;
        ae_req_valid = 1'b0;
        ae_req_dur = '0;
        FrameDurationChangeEnable = 1'b0;
        FrameDurationCurrentClks = DUR_W'(1000);
        error_clr = 1'b0;
        modelLastAe = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checkResetState();
        checkVal("rst_applied_dur", 32'(applied_dur), 0);

        for (int i = 0; i < 60; i++) begin
            runTxn(int'($urandom_range(0, 2)));
        end

        // Abandon a request mid-confirm with an asynchronous reset.
        host_req_valid = 1'b1;
        host_req_dur = DUR_W'(7000);
        FrameDurationCurrentClks = DUR_W'(1000);
        tick();
        host_req_valid = 1'b0;
        repeat (2) tick();
        FrameDurationChangeEnable = 1'b1;
        tick();
        FrameDurationChangeEnable = 1'b0;
        checkVal("pre_reset_busy", 32'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        checkResetState();
        FrameDurationCurrentClks = DUR_W'(7000);
        tick();
        checkVal("in_reset_no_pulse", 32'(applied_valid), 0);
        #3;
        reset = 1'b1;
        modelLastAe = 1'b1;
        tick();
        checkVal("post_reset_no_pulse", 32'(applied_valid), 0);
        checkVal("post_reset_busy", 32'(busy), 0);
        checkVal("post_reset_requested", 32'(FrameDurationRequestedClks), 1000);

        for (int i = 0; i < 10; i++) begin
            runTxn(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
